gen_round_keys: RTL and testbench



---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_sub_word.sv | 15 +
 rtl/gen_round_keys.sv | 123 ++++++++++++
 tb/tb_gen_round_keys.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and types: S-box, round constants, word/block
// typedefs and the AES-128 round count.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int NUM_ROUNDS = 10;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for rounds 1..10 (index 0 is round 1).
    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    // Four parallel byte lookups.
    always_comb begin
        out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                    sbox(in_word[15:8]),  sbox(in_word[7:0])};
    end

endmodule

// File: rtl/gen_round_keys.sv
// AES-128 key schedule: on a chg_key rising edge, latch rx_key and expand
// it into 11 round keys, one per cycle, into an internal table. cur_key
// returns table[cur_round] one cycle after the request.
// Optional macro GEN_ROUND_KEYS_LOCK_EN: blank cur_key while expanding.
module gen_round_keys
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         chg_key,
    input  logic [127:0] rx_key,
    input  logic [3:0]   cur_round,
    output logic [127:0] cur_key,
    output logic [127:0] orig_key,
    output logic         change_key_done
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        chg_prev_q;
    logic        done_q, done_d;
    block_t      orig_key_q, orig_key_d;
    block_t      cur_key_q, cur_key_d;
    block_t      table_q [0:NUM_ROUNDS];
    block_t      table_d [0:NUM_ROUNDS];

    logic        start;
    logic [3:0]  prev_idx;
    block_t      prev_rk, next_rk;
    word_t       rot_word, sub_word, temp_word;
    word_t       nw0, nw1, nw2, nw3;

    // Only a fresh 0->1 transition seen while idle starts an expansion.
    assign start = (state_q == IDLE) && chg_key && !chg_prev_q;

    assign prev_idx = cnt_q - 4'd1;

    aes_sub_word u_sub_word (
        .in_word  (rot_word),
        .out_word (sub_word)
    );

    // One round of the expansion: derive table[cnt] from table[cnt-1].
    always_comb begin
        prev_rk   = table_q[prev_idx];
        rot_word  = {prev_rk[23:0], prev_rk[31:24]};
        temp_word = sub_word ^ {RCON[prev_idx], 24'h0};
        nw0       = prev_rk[127:96] ^ temp_word;
        nw1       = prev_rk[95:64]  ^ nw0;
        nw2       = prev_rk[63:32]  ^ nw1;
        nw3       = prev_rk[31:0]   ^ nw2;
        next_rk   = {nw0, nw1, nw2, nw3};
    end

    // Control FSM and key-table write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        orig_key_d = orig_key_q;
        table_d    = table_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    orig_key_d = rx_key;
                    table_d[0] = rx_key;
                    cnt_d      = 4'd1;
                    state_d    = EXPAND;
                end
            end
            EXPAND: begin
                table_d[cnt_q] = next_rk;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'(NUM_ROUNDS)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered read port; out-of-range rounds read as zero.
    always_comb begin
        cur_key_d = '0;
        if (cur_round <= 4'(NUM_ROUNDS))
            cur_key_d = table_q[cur_round];
`ifdef GEN_ROUND_KEYS_LOCK_EN
        if (state_q == EXPAND || start)
            cur_key_d = '0;
`endif
    end

    // State registers; reset aborts any expansion and wipes the table.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chg_prev_q <= 1'b0;
            done_q     <= 1'b0;
            orig_key_q <= '0;
            cur_key_q  <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++)
                table_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chg_prev_q <= chg_key;
            done_q     <= done_d;
            orig_key_q <= orig_key_d;
            cur_key_q  <= cur_key_d;
            for (int i = 0; i <= NUM_ROUNDS; i++)
                table_q[i] <= table_d[i];
        end
    end

    assign cur_key         = cur_key_q;
    assign orig_key        = orig_key_q;
    assign change_key_done = done_q;

endmodule

// File: tb/tb_gen_round_keys.sv
// Self-checking bench for gen_round_keys: table of known round keys,
// scoreboard queue for registered reads, plus hand-written sequences for
// done timing, held/toggled chg_key and mid-expansion reset.
module tb_gen_round_keys;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         chg_key;
    logic [127:0] rx_key;
    logic [3:0]   cur_round;
    logic [127:0] cur_key;
    logic [127:0] orig_key;
    logic         change_key_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] sb_q [$];

    typedef struct {
        logic [3:0]   round;
        logic [127:0] exp_key;
    } vec_t;

    vec_t vecs [0:10];

    localparam logic [127:0] KEY_A = 128'h68656c6c6f3030303030303030303030;
    localparam logic [127:0] KEY_F = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_F_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    gen_round_keys dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .chg_key         (chg_key),
        .rx_key          (rx_key),
        .cur_round       (cur_round),
        .cur_key         (cur_key),
        .orig_key        (orig_key),
        .change_key_done (change_key_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one read; expected value goes through the scoreboard.
    task automatic read_round(input logic [3:0] r, input logic [127:0] exp, input string name);
        logic [127:0] e;
        @(negedge clk);
        cur_round = r;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(name, cur_key, e);
    endtask

    // Start an expansion and watch 20 edges; edge 0 is the sampling edge.
    task automatic load_key(input logic [127:0] k, output int done_edge, output int pulses);
        @(negedge clk);
        rx_key    = k;
        chg_key   = 1'b1;
        cur_round = 4'd0;
        done_edge = -1;
        pulses    = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (change_key_done) begin
                pulses++;
                if (done_edge < 0) done_edge = e;
            end
            if (e == 2) begin
`ifdef GEN_ROUND_KEYS_LOCK_EN
                check("lock_during_expand", cur_key, 128'h0);
`else
                check("read_during_expand", cur_key, k);
`endif
            end
        end
        @(negedge clk);
        chg_key = 1'b0;
    endtask

    int de, np;

    initial begin
        vecs[0]  = '{4'd0,  KEY_A};
        vecs[1]  = '{4'd1,  128'h6d616868025158583261686802515858};
        vecs[2]  = '{4'd2,  128'hbe0b021fbc5a5a478e3b322f8c6a6a77};
        vecs[3]  = '{4'd3,  128'hb809f77b0453ad3c8a689f130602f564};
        vecs[4]  = '{4'd4,  128'hc7efb414c3bc192849d4863b4fd6735f};
        vecs[5]  = '{4'd5,  128'h21607b90e2dc62b8ab08e483e4de97dc};
        vecs[6]  = '{4'd6,  128'h1ce8fdf9fe349f41553c7bc2b1e2ec1e};
        vecs[7]  = '{4'd7,  128'hc4268f313a1210706f2e6bb2decc87ac};
        vecs[8]  = '{4'd8,  128'h0f311e2c35230e5c5a0d65ee84c1e242};
        vecs[9]  = '{4'd9,  128'h6ca93273598a3c2f038759c18746bb83};
        vecs[10] = '{4'd10, 128'h0043de6459c9e24b5a4ebb8add080009};

        n_rst = 1'b0; chg_key = 1'b0; rx_key = '0; cur_round = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cur_key",  cur_key, 128'h0);
        check("rst_orig_key", orig_key, 128'h0);
        check("rst_done",     {127'h0, change_key_done}, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // Known-answer load and full table sweep.
        load_key(KEY_A, de, np);
        check("a_done_edge", 128'(de), 128'd10);
        check("a_done_pulses", 128'(np), 128'd1);
        for (int i = 0; i <= 10; i++) begin
            read_round(vecs[i].round, vecs[i].exp_key, $sformatf("a_round%0d", i));
            check("a_orig_key", orig_key, KEY_A);
        end

        // Out-of-order reads and out-of-range index.
        read_round(4'd10, vecs[10].exp_key, "ooo_r10");
        read_round(4'd1,  vecs[1].exp_key,  "ooo_r1");
        read_round(4'd0,  KEY_A,            "ooo_r0");
        read_round(4'd12, 128'h0,           "range_r12");
        read_round(4'd15, 128'h0,           "range_r15");

        // FIPS-197 key: round 10 and done timing.
        load_key(KEY_F, de, np);
        check("f_done_edge", 128'(de), 128'd10);
        check("f_done_pulses", 128'(np), 128'd1);
        read_round(4'd10, KEY_F_R10, "f_round10");
        check("f_orig_key", orig_key, KEY_F);

        // chg_key held high for 30 cycles: one expansion only.
        @(negedge clk);
        rx_key = KEY_A; chg_key = 1'b1;
        np = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (change_key_done) np++;
        end
        @(negedge clk); chg_key = 1'b0;
        check("hold_pulses", 128'(np), 128'd1);
        read_round(4'd10, vecs[10].exp_key, "hold_round10");

        // Toggle chg_key and change rx_key mid-expansion: both ignored.
        @(negedge clk);
        rx_key = KEY_F; chg_key = 1'b1;
        np = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (change_key_done) np++;
            if (c == 3) begin @(negedge clk); chg_key = 1'b0; rx_key = KEY_A; end
            if (c == 5) begin @(negedge clk); chg_key = 1'b1; end
        end
        @(negedge clk); chg_key = 1'b0;
        check("toggle_pulses", 128'(np), 128'd1);
        check("toggle_orig_key", orig_key, KEY_F);
        read_round(4'd10, KEY_F_R10, "toggle_round10");

        // Reset at round 5 of an expansion.
        @(negedge clk);
        rx_key = KEY_A; chg_key = 1'b1; cur_round = 4'd0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0; chg_key = 1'b0;
        #1;
        check("rst_mid_cur_key",  cur_key, 128'h0);
        check("rst_mid_orig_key", orig_key, 128'h0);
        check("rst_mid_done",     {127'h0, change_key_done}, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;
        np = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (change_key_done) np++;
        end
        check("rst_mid_no_pulse", 128'(np), 128'd0);
        read_round(4'd5, 128'h0, "rst_mid_table_clear");

        // Fresh load after the aborted one.
        load_key(KEY_A, de, np);
        check("fresh_done_edge", 128'(de), 128'd10);
        read_round(4'd10, vecs[10].exp_key, "fresh_round10");
        read_round(4'd3,  vecs[3].exp_key,  "fresh_round3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
